para_select_fsm: RTL and testbench

- Parameter-selection front end for the pulse generator's front-panel display.
- Holds the currently selected parameter index and steps through a parametrised number of parameters with wrap-around, driven by NEXT/PREV/SEL button pulses.
- Drives a registered two-character label, and in EDIT mode blinks the label and forwards value-adjust pulses to the downstream parameter registers.
- Generalises the fixed 12-entry combinational label decode: adds parameter count, index state, edit mode, blink and edit timeout.

---
 rtl/para_pkg.sv | 43 ++++
 rtl/para_label_rom.sv | 35 +++
 rtl/para_select_fsm.sv | 132 +++++++++++++
 tb/tb_para_select_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/para_pkg.sv
// Shared definitions for the front-panel parameter selector: character codes,
// FSM state encoding and the index-to-label table.
package para_pkg;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] CH_N     = 4'hA;
  localparam logic [CODE_W-1:0] CH_B     = 4'hB;
  localparam logic [CODE_W-1:0] CH_C     = 4'hC;
  localparam logic [CODE_W-1:0] CH_D     = 4'hD;
  localparam logic [CODE_W-1:0] CH_E     = 4'hE;
  localparam logic [CODE_W-1:0] CH_BLANK = 4'hF;

  typedef enum logic [0:0] {
    ST_BROWSE = 1'b0,
    ST_EDIT   = 1'b1
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] left;
    logic [CODE_W-1:0] right;
  } label_t;

  // Indices beyond the named set show a fully blank label.
  function automatic label_t para_label(input int unsigned idx);
    case (idx)
      0:       return '{left: CH_N,     right: 4'h1};
      1:       return '{left: CH_N,     right: 4'h2};
      2:       return '{left: CH_B,     right: CH_BLANK};
      3:       return '{left: CH_C,     right: CH_BLANK};
      4:       return '{left: CH_D,     right: CH_BLANK};
      5:       return '{left: CH_B,     right: 4'h1};
      6:       return '{left: CH_C,     right: 4'h1};
      7:       return '{left: CH_B,     right: 4'h2};
      8:       return '{left: CH_D,     right: 4'h1};
      9:       return '{left: CH_E,     right: CH_BLANK};
      10:      return '{left: CH_D,     right: 4'h2};
      11:      return '{left: CH_C,     right: 4'h2};
      default: return '{left: CH_BLANK, right: CH_BLANK};
    endcase
  endfunction

endpackage

// File: rtl/para_label_rom.sv
// Registered label lookup: turns the selected index and blink phase into the
// two display characters, zero-extending each code to CHAR_W.
module para_label_rom
  import para_pkg::*;
#(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CHAR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic                blank_i,
  output logic [2*CHAR_W-1:0] label_o
);

  localparam logic [2*CHAR_W-1:0] RST_LABEL   = {CHAR_W'(CH_N), CHAR_W'(4'h1)};
  localparam logic [2*CHAR_W-1:0] BLANK_LABEL = {CHAR_W'(CH_BLANK), CHAR_W'(CH_BLANK)};

  label_t                lbl_c;
  logic [2*CHAR_W-1:0]   label_d;
  logic [2*CHAR_W-1:0]   label_q;

  always_comb begin
    lbl_c   = para_label(32'(idx_i));
    label_d = blank_i ? BLANK_LABEL : {CHAR_W'(lbl_c.left), CHAR_W'(lbl_c.right)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) label_q <= RST_LABEL;
    else        label_q <= label_d;
  end

  assign label_o = label_q;

endmodule

// File: rtl/para_select_fsm.sv
// Parameter-selection front end: BROWSE steps the index with wrap-around,
// EDIT blinks the label and turns NEXT/PREV into value adjust pulses.
module para_select_fsm
  import para_pkg::*;
#(
  parameter int unsigned NUM_PARAMS = 12,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned CHAR_W     = 4,
  parameter int unsigned BLINK_HALF = 12_500_000,
  parameter int unsigned TIMEOUT    = 250_000_000
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic                BTN_NEXT,
  input  logic                BTN_PREV,
  input  logic                BTN_SEL,
  output logic [IDX_W-1:0]    PARA_IDX,
  output logic [2*CHAR_W-1:0] PARA_OUT,
  output logic                EDIT,
  output logic                BLANK,
  output logic                VAL_INC,
  output logic                VAL_DEC
);

  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_PARAMS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic [TMO_W-1:0]     idle_q, idle_d;
  logic                 blank_q, blank_d;
  logic                 inc_q, inc_d;
  logic                 dec_q, dec_d;
  logic                 step_c;
  logic                 any_c;

  // NEXT and PREV together cancel out; any pulse still counts as activity.
  assign step_c = BTN_NEXT ^ BTN_PREV;
  assign any_c  = BTN_NEXT | BTN_PREV | BTN_SEL;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_BROWSE;
      idx_q   <= '0;
      blink_q <= '0;
      idle_q  <= '0;
      blank_q <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      idle_q  <= idle_d;
      blank_q <= blank_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blink_d = blink_q;
    idle_d  = idle_q;
    blank_d = blank_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;

    case (state_q)
      ST_BROWSE: begin
        blink_d = '0;
        idle_d  = '0;
        blank_d = 1'b0;
        if (BTN_SEL) begin
          state_d = ST_EDIT;
        end else if (step_c) begin
          if (BTN_NEXT) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          else          idx_d = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
        end
      end

      ST_EDIT: begin
        if (BTN_SEL || (!any_c && idle_q == TMO_LAST)) begin
          state_d = ST_BROWSE;
          blink_d = '0;
          idle_d  = '0;
          blank_d = 1'b0;
        end else begin
          idle_d = any_c ? '0 : idle_q + TMO_W'(1);
          // Adjusting restarts the blink so the label stays readable.
          if (step_c) begin
            inc_d   = BTN_NEXT;
            dec_d   = BTN_PREV;
            blink_d = '0;
            blank_d = 1'b0;
          end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            blank_d = ~blank_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
      end

      default: state_d = ST_BROWSE;
    endcase
  end

  para_label_rom #(
    .IDX_W  (IDX_W),
    .CHAR_W (CHAR_W)
  ) u_label_rom (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .idx_i   (idx_q),
    .blank_i (blank_q),
    .label_o (PARA_OUT)
  );

  assign PARA_IDX = idx_q;
  assign EDIT     = (state_q == ST_EDIT);
  assign BLANK    = blank_q;
  assign VAL_INC  = inc_q;
  assign VAL_DEC  = dec_q;

endmodule

// File: tb/tb_para_select_fsm.sv
// Bench for para_select_fsm: directed scenarios plus random button traffic
// compared against a time-since-activity model of browse/edit behaviour.
module tb_para_select_fsm;

  localparam int NP = 12;
  localparam int BH = 4;
  localparam int TO = 20;

  logic       CLOCK;
  logic       RESET_N;
  logic       BTN_NEXT, BTN_PREV, BTN_SEL;
  logic [3:0] idx12, idx14;
  logic [7:0] out12, out14;
  logic       ed12, bl12, inc12, dec12;
  logic       ed14, bl14, inc14, dec14;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  int         m_idx, m_edit, m_since, m_quiet, m_inc, m_dec;
  logic [7:0] m_label;

  para_select_fsm #(.NUM_PARAMS(12), .IDX_W(4), .CHAR_W(4), .BLINK_HALF(BH), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .BTN_NEXT(BTN_NEXT), .BTN_PREV(BTN_PREV), .BTN_SEL(BTN_SEL),
    .PARA_IDX(idx12), .PARA_OUT(out12), .EDIT(ed12), .BLANK(bl12), .VAL_INC(inc12), .VAL_DEC(dec12));

  para_select_fsm #(.NUM_PARAMS(14), .IDX_W(4), .CHAR_W(4), .BLINK_HALF(BH), .TIMEOUT(TO)) dut14 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .BTN_NEXT(BTN_NEXT), .BTN_PREV(BTN_PREV), .BTN_SEL(BTN_SEL),
    .PARA_IDX(idx14), .PARA_OUT(out14), .EDIT(ed14), .BLANK(bl14), .VAL_INC(inc14), .VAL_DEC(dec14));

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] lbl(input int i);
    case (i)
      0: return 8'hA1;  1: return 8'hA2;  2: return 8'hBF;  3: return 8'hCF;
      4: return 8'hDF;  5: return 8'hB1;  6: return 8'hC1;  7: return 8'hB2;
      8: return 8'hD1;  9: return 8'hEF; 10: return 8'hD2; 11: return 8'hC2;
      default: return 8'hFF;
    endcase
  endfunction

  // Blink phase follows from edges elapsed since EDIT entry or last adjust.
  function automatic bit model_blank();
    return (m_edit != 0) && (((m_since / BH) % 2) == 1);
  endfunction

  function automatic void model_reset();
    m_idx = 0; m_edit = 0; m_since = 0; m_quiet = 0;
    m_inc = 0; m_dec = 0; m_label = 8'hA1;
  endfunction

  function automatic void model_edge(input bit n, input bit p, input bit s);
    bit act;
    act     = n ^ p;
    m_label = model_blank() ? 8'hFF : lbl(m_idx);
    m_inc   = 0;
    m_dec   = 0;
    if (m_edit == 0) begin
      if (s) begin
        m_edit = 1; m_since = 0; m_quiet = 0;
      end else if (act) begin
        m_idx = n ? (m_idx + 1) % NP : (m_idx + NP - 1) % NP;
      end
    end else if (s) begin
      m_edit = 0;
    end else begin
      if (n || p) m_quiet = 0; else m_quiet++;
      if (act) begin m_since = 0; m_inc = n; m_dec = p; end
      else m_since++;
      if (m_quiet == TO) m_edit = 0;
    end
  endfunction

  task automatic tick(input bit n, input bit p, input bit s);
    BTN_NEXT = n; BTN_PREV = p; BTN_SEL = s;
    @(posedge CLOCK);
    model_edge(n, p, s);
    #1;
    BTN_NEXT = 1'b0; BTN_PREV = 1'b0; BTN_SEL = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; BTN_NEXT = 1'b0; BTN_PREV = 1'b0; BTN_SEL = 1'b0;
    repeat (2) @(negedge CLOCK);
    vecs++; if (idx12 !== 4'd0)  begin errs++; $display("FAIL reset_idx got %0d want 0", idx12); end
    vecs++; if (out12 !== 8'hA1) begin errs++; $display("FAIL reset_out got %h want a1", out12); end
    vecs++; if ({ed12, bl12, inc12, dec12} !== 4'b0000)
      begin errs++; $display("FAIL reset_flags got %b want 0000", {ed12, bl12, inc12, dec12}); end
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_next_wrap();
    for (int i = 0; i < 12; i++) begin
      tick(1, 0, 0);
      vecs++; if (idx12 !== 4'((i + 1) % 12))
        begin errs++; $display("FAIL next_idx step %0d got %0d want %0d", i, idx12, (i + 1) % 12); end
      tick(0, 0, 0);
      vecs++; if (out12 !== lbl((i + 1) % 12))
        begin errs++; $display("FAIL next_label step %0d got %h want %h", i, out12, lbl((i + 1) % 12)); end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_prev_both();
    tick(0, 1, 0);
    vecs++; if (idx12 !== 4'd11) begin errs++; $display("FAIL prev_wrap got %0d want 11", idx12); end
    tick(0, 0, 0);
    vecs++; if (out12 !== 8'hC2) begin errs++; $display("FAIL prev_label got %h want c2", out12); end
    tick(1, 1, 0);
    vecs++; if (idx12 !== 4'd11) begin errs++; $display("FAIL both_noop got %0d want 11", idx12); end
    tick(0, 0, 0);
  endtask

  task automatic test_edit_adjust();
    int n_inc, n_dec;
    n_inc = 0; n_dec = 0;
    tick(0, 0, 1);
    vecs++; if (ed12 !== 1'b1) begin errs++; $display("FAIL edit_enter got %b want 1", ed12); end
    tick(1, 0, 0); n_inc += int'(inc12); n_dec += int'(dec12);
    tick(0, 0, 0); n_inc += int'(inc12); n_dec += int'(dec12);
    tick(1, 0, 0); n_inc += int'(inc12); n_dec += int'(dec12);
    tick(0, 0, 0); n_inc += int'(inc12); n_dec += int'(dec12);
    tick(0, 1, 0); n_inc += int'(inc12); n_dec += int'(dec12);
    vecs++; if (dec12 !== 1'b1) begin errs++; $display("FAIL dec_pulse got %b want 1", dec12); end
    vecs++; if (idx12 !== 4'd11) begin errs++; $display("FAIL edit_frozen got %0d want 11", idx12); end
    for (int k = 1; k <= 9; k++) begin
      tick(0, 0, 0); n_inc += int'(inc12); n_dec += int'(dec12);
      vecs++; if (bl12 !== ((k >= 4 && k < 8) ? 1'b1 : 1'b0))
        begin errs++; $display("FAIL adj_blank k=%0d got %b want %b", k, bl12, (k >= 4 && k < 8)); end
      vecs++; if (out12 !== ((k >= 5 && k <= 8) ? 8'hFF : 8'hC2))
        begin errs++; $display("FAIL adj_label k=%0d got %h", k, out12); end
    end
    vecs++; if (n_inc !== 2) begin errs++; $display("FAIL inc_count got %0d want 2", n_inc); end
    vecs++; if (n_dec !== 1) begin errs++; $display("FAIL dec_count got %0d want 1", n_dec); end
    tick(0, 0, 1);
    vecs++; if ({ed12, bl12, inc12} !== 3'b000)
      begin errs++; $display("FAIL edit_exit got %b want 000", {ed12, bl12, inc12}); end
  endtask

  task automatic test_timeout();
    bit prev_bl;
    tick(0, 0, 1);
    prev_bl = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick(0, 0, 0);
      vecs++; if (ed12 !== ((k < 20) ? 1'b1 : 1'b0))
        begin errs++; $display("FAIL tmo_edit k=%0d got %b", k, ed12); end
      vecs++; if (bl12 !== ((k < 20 && ((k / 4) % 2) == 1) ? 1'b1 : 1'b0))
        begin errs++; $display("FAIL tmo_blank k=%0d got %b", k, bl12); end
      vecs++; if (out12 !== (prev_bl ? 8'hFF : 8'hC2))
        begin errs++; $display("FAIL tmo_label k=%0d got %h want %h", k, out12, prev_bl ? 8'hFF : 8'hC2); end
      prev_bl = (k < 20 && ((k / 4) % 2) == 1);
    end
  endtask

  task automatic test_sel_priority();
    tick(1, 0, 1);
    vecs++; if ({ed12, inc12} !== 2'b10) begin errs++; $display("FAIL sel_prio got %b want 10", {ed12, inc12}); end
    vecs++; if (idx12 !== 4'd11) begin errs++; $display("FAIL sel_prio_idx got %0d want 11", idx12); end
    tick(0, 0, 0);
    @(negedge CLOCK); #2;
    RESET_N = 1'b0;
    #1;
    vecs++; if (idx12 !== 4'd0)  begin errs++; $display("FAIL async_idx got %0d want 0", idx12); end
    vecs++; if (ed12 !== 1'b0)   begin errs++; $display("FAIL async_edit got %b want 0", ed12); end
    vecs++; if (out12 !== 8'hA1) begin errs++; $display("FAIL async_label got %h want a1", out12); end
    model_reset();
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, (c < 200) ? 15 : 63));
      tick(r == 0 || r == 3 || r == 4, r == 1 || r == 3, r == 2 || r == 4);
      vecs++; if (idx12 !== 4'(m_idx))
        begin errs++; $display("FAIL rnd_idx c=%0d got %0d want %0d", c, idx12, m_idx); end
      vecs++; if (ed12 !== 1'(m_edit))
        begin errs++; $display("FAIL rnd_edit c=%0d got %b want %0d", c, ed12, m_edit); end
      vecs++; if (bl12 !== model_blank())
        begin errs++; $display("FAIL rnd_blank c=%0d got %b want %b", c, bl12, model_blank()); end
      vecs++; if ({inc12, dec12} !== {1'(m_inc), 1'(m_dec)})
        begin errs++; $display("FAIL rnd_val c=%0d got %b want %0d%0d", c, {inc12, dec12}, m_inc, m_dec); end
      vecs++; if (out12 !== m_label)
        begin errs++; $display("FAIL rnd_label c=%0d got %h want %h", c, out12, m_label); end
    end
  endtask

  task automatic test_14();
    RESET_N = 1'b0;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    model_reset();
    tick(0, 1, 0);
    vecs++; if (idx14 !== 4'd13) begin errs++; $display("FAIL p14_prev got %0d want 13", idx14); end
    tick(0, 0, 0);
    vecs++; if (out14 !== 8'hFF) begin errs++; $display("FAIL p14_lbl13 got %h want ff", out14); end
    tick(1, 0, 0);
    vecs++; if (idx14 !== 4'd0) begin errs++; $display("FAIL p14_wrap got %0d want 0", idx14); end
    for (int i = 1; i <= 12; i++) begin
      tick(1, 0, 0);
      vecs++; if (idx14 !== 4'(i)) begin errs++; $display("FAIL p14_step got %0d want %0d", idx14, i); end
    end
    tick(0, 0, 0);
    vecs++; if (out14 !== 8'hFF) begin errs++; $display("FAIL p14_lbl12 got %h want ff", out14); end
    tick(1, 0, 0);
    tick(1, 0, 0);
    vecs++; if (idx14 !== 4'd0) begin errs++; $display("FAIL p14_wrap2 got %0d want 0", idx14); end
    tick(0, 0, 0);
    vecs++; if (out14 !== 8'hA1) begin errs++; $display("FAIL p14_lbl0 got %h want a1", out14); end
  endtask

  initial begin
    test_reset();
    test_next_wrap();
    test_prev_both();
    test_edit_adjust();
    test_timeout();
    test_sel_priority();
    test_random();
    test_14();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
